// File: rtl/adcv_pkg.sv
// Shared constants, FSM state type and window-length clamp for the ADC code decimator.
package adcv_pkg;

    localparam int DEF_CODE_W    = 8;
    localparam int DEF_MAX_LOG2N = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } dec_state_e;

    // Requested log2 window lengths above the supported maximum fall back to the maximum.
    function automatic logic [7:0] clamp_l2n(input logic [7:0] log2n,
                                             input int unsigned max_l2n = DEF_MAX_LOG2N);
        if (32'(log2n) > max_l2n) begin
            return 8'(max_l2n);
        end
        return log2n;
    endfunction

endpackage

// File: rtl/adc_dec_out_hold.sv
// Result holding register with valid/ready handshake and sticky overrun flag.
// Optional min/max result fields are present when ADC_DEC_MINMAX_EN is defined.
module adc_dec_out_hold
    import adcv_pkg::*;
#(
    parameter int B     = DEF_CODE_W,
    parameter int ACC_W = DEF_CODE_W + DEF_MAX_LOG2N
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_req,
    input  logic [ACC_W-1:0] in_sum,
    input  logic [B-1:0]     in_mean,
`ifdef ADC_DEC_MINMAX_EN
    input  logic [B-1:0]     in_min,
    input  logic [B-1:0]     in_max,
    output logic [B-1:0]     out_min,
    output logic [B-1:0]     out_max,
`endif
    input  logic             clr_overrun,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum,
    output logic [B-1:0]     out_mean,
    output logic             overrun
);

    // Handshake: a result transfers on any edge where out_valid && out_ready; while
    // out_valid is high without out_ready the held data must not change.
    logic             valid_q, valid_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [B-1:0]     mean_q, mean_d;
    logic             overrun_q, overrun_d;
    logic             load;
    logic             drop;

    assign load = load_req && (!valid_q || out_ready);
    assign drop = load_req && valid_q && !out_ready;

    always_comb begin
        valid_d   = valid_q;
        sum_d     = sum_q;
        mean_d    = mean_q;
        overrun_d = (overrun_q && !clr_overrun) || drop;
        if (load) begin
            valid_d = 1'b1;
            sum_d   = in_sum;
            mean_d  = in_mean;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            sum_q     <= '0;
            mean_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            sum_q     <= sum_d;
            mean_q    <= mean_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef ADC_DEC_MINMAX_EN
    logic [B-1:0] min_q, min_d;
    logic [B-1:0] max_q, max_d;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (load) begin
            min_d = in_min;
            max_d = in_max;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign out_min = min_q;
    assign out_max = max_q;
`endif

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_mean  = mean_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/adc_code_decimator.sv
// Window accumulator/decimator for binary ADC codes: emits sum and mean per 2^log2n samples.
// Define ADC_DEC_MINMAX_EN to add per-window out_min/out_max outputs.
module adc_code_decimator
    import adcv_pkg::*;
#(
    parameter  int B         = DEF_CODE_W,
    parameter  int MAX_LOG2N = DEF_MAX_LOG2N,
    localparam int ACC_W     = B + MAX_LOG2N,
    localparam int L2N_W     = $clog2(MAX_LOG2N + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [L2N_W-1:0] log2n,
    input  logic             in_valid,
    input  logic [B-1:0]     in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [B-1:0]     out_mean,
`ifdef ADC_DEC_MINMAX_EN
    output logic [B-1:0]     out_min,
    output logic [B-1:0]     out_max,
`endif
    output logic             overrun,
    output logic             state_dbg
);

    dec_state_e           state_q, state_d;
    logic [L2N_W-1:0]     win_l2_q, win_l2_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [MAX_LOG2N-1:0] cnt_q, cnt_d;
    logic                 en_prev_q, en_prev_d;
    logic                 complete;
    logic [ACC_W-1:0]     win_sum;
    logic [B-1:0]         win_mean;
    logic [MAX_LOG2N:0]   n_full;
    logic [MAX_LOG2N-1:0] last_cnt;

    assign n_full   = (MAX_LOG2N + 1)'(1) << win_l2_q;
    assign last_cnt = MAX_LOG2N'(n_full - (MAX_LOG2N + 1)'(1));
    // Sum including the current sample; only meaningful as a result when complete is high.
    assign win_sum  = acc_q + ACC_W'(in_code);
    assign win_mean = B'(win_sum >> win_l2_q);
    assign en_prev_d = enable;

    always_comb begin
        state_d  = state_q;
        win_l2_d = win_l2_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (enable) begin
                    win_l2_d = L2N_W'(clamp_l2n(8'(log2n), MAX_LOG2N));
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (in_valid) begin
                    if (cnt_q == last_cnt) begin
                        complete = 1'b1;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        acc_d = win_sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            win_l2_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            en_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_l2_q  <= win_l2_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            en_prev_q <= en_prev_d;
        end
    end

`ifdef ADC_DEC_MINMAX_EN
    logic [B-1:0] min_q, min_d;
    logic [B-1:0] max_q, max_d;
    logic [B-1:0] win_min, win_max;

    // The first sample of each window seeds the trackers.
    assign win_min = (cnt_q == '0 || in_code < min_q) ? in_code : min_q;
    assign win_max = (cnt_q == '0 || in_code > max_q) ? in_code : max_q;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (state_q == ACCUM && enable && in_valid) begin
            min_d = win_min;
            max_d = win_max;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end
`endif

    adc_dec_out_hold #(
        .B     (B),
        .ACC_W (ACC_W)
    ) u_out_hold (
        .clock       (clock),
        .reset       (reset),
        .load_req    (complete),
        .in_sum      (win_sum),
        .in_mean     (win_mean),
`ifdef ADC_DEC_MINMAX_EN
        .in_min      (win_min),
        .in_max      (win_max),
        .out_min     (out_min),
        .out_max     (out_max),
`endif
        .clr_overrun (en_prev_q && !enable),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_sum     (out_sum),
        .out_mean    (out_mean),
        .overrun     (overrun)
    );

    assign state_dbg = state_q;

endmodule
